equiv_stream_checker: RTL

Registered equivalence checker for the identity-proof harness. It compares two DUT output streams (y_a, y_b) of parametrised width. It adds per-side latency alignment, a warm-up mask, saturating statistics and capture of the first miscompare. It sits in the proof/sim top between the two DUT instances, replacing the bare per-clock equality assert. Its outputs feed the formal property or the sim scoreboard.

---
 rtl/equiv_pkg.sv | 19 +
 rtl/equiv_delay_line.sv | 49 ++++
 rtl/equiv_stream_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/equiv_pkg.sv
// Shared types and constants for the stream equivalence checker: state encoding,
// default widths and the delay-fill helper.
package equiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAIL   = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 91;
    localparam int DEFAULT_CNT_W = 16;

    function automatic int max_delay(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/equiv_delay_line.sv
// Enable-gated shift register of DEPTH stages carrying a valid bit alongside the
// data; DEPTH=0 is a direct path that is always valid.
module equiv_delay_line
    import equiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    genvar gi;

    generate
        if (DEPTH == 0) begin : g_direct
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, clear_i, en_i};
            assign q_o       = d_i;
            assign valid_o   = 1'b1;
        end else begin : g_pipe
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                // Top bit of each stage is the valid flag, filled with 1s from the head.
                logic [WIDTH:0] stage_q;
                logic [WIDTH:0] stage_d;
                if (gi == 0) begin : g_head
                    assign stage_d = {1'b1, d_i};
                end else begin : g_tail
                    assign stage_d = g_stage[gi-1].stage_q;
                end
                always_ff @(posedge clk) begin
                    if (!rst_n || clear_i) begin
                        stage_q <= '0;
                    end else if (en_i) begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign q_o     = g_stage[DEPTH-1].stage_q[WIDTH-1:0];
            assign valid_o = g_stage[DEPTH-1].stage_q[WIDTH];
        end
    endgenerate

endmodule

// File: rtl/equiv_stream_checker.sv
// Registered equivalence checker for two DUT output streams with latency alignment,
// warm-up mask, saturating statistics and first-miscompare capture.
// Define EQUIV_ASSERT_EN to add an immediate assertion on every compare.
module equiv_stream_checker
    import equiv_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int A_DELAY      = 0,
    parameter int B_DELAY      = 0,
    parameter int WARMUP       = 0,
    parameter int STOP_ON_FAIL = 1,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] y_a,
    input  logic [WIDTH-1:0] y_b,
    output logic             mismatch,
    output logic             fail,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] first_cycle,
    output logic [WIDTH-1:0] first_diff
);

    localparam int               FILL    = max_delay(A_DELAY, B_DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [8:0]       WARM_N  = 9'(WARMUP);

    logic [WIDTH-1:0] a_al, b_al, diff;
    logic             a_vld, b_vld, aligned_valid;

    state_e           state_q, state_d;
    logic [8:0]       warm_q, warm_d;
    logic             mismatch_q, mismatch_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic [CNT_W-1:0] fcyc_q, fcyc_d;
    logic [WIDTH-1:0] fdiff_q, fdiff_d;
    logic             do_compare, miscompare;

    equiv_delay_line #(.WIDTH(WIDTH), .DEPTH(A_DELAY)) u_dly_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (en),
        .d_i     (y_a),
        .q_o     (a_al),
        .valid_o (a_vld)
    );

    equiv_delay_line #(.WIDTH(WIDTH), .DEPTH(B_DELAY)) u_dly_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (en),
        .d_i     (y_b),
        .q_o     (b_al),
        .valid_o (b_vld)
    );

    assign aligned_valid = (FILL == 0) ? 1'b1 : (a_vld & b_vld);
    assign diff          = a_al ^ b_al;

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        do_compare = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    // With no warm-up the very first aligned sample is already compared.
                    if (WARMUP == 0) begin
                        state_d    = ST_RUN;
                        do_compare = aligned_valid;
                    end else begin
                        state_d = ST_WARMUP;
                        if (aligned_valid) begin
                            warm_d = 9'd1;
                            if (WARM_N == 9'd1) begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                end
                ST_WARMUP: begin
                    if (aligned_valid) begin
                        warm_d = warm_q + 9'd1;
                        if (warm_q + 9'd1 == WARM_N) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    do_compare = aligned_valid;
                end
                default: ;
            endcase
        end

        miscompare = do_compare && (diff != '0);
        if (miscompare && (STOP_ON_FAIL != 0)) begin
            state_d = ST_FAIL;
        end

        mismatch_d = miscompare;
        fail_d     = fail_q | miscompare;
        mcnt_d     = (miscompare && (mcnt_q != CNT_MAX)) ? mcnt_q + 1'b1 : mcnt_q;
        ccnt_d     = (en && (ccnt_q != CNT_MAX)) ? ccnt_q + 1'b1 : ccnt_q;
        fcyc_d     = fcyc_q;
        fdiff_d    = fdiff_q;
        if (miscompare && !fail_q) begin
            fcyc_d  = ccnt_q;
            fdiff_d = diff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q    <= ST_IDLE;
            warm_q     <= '0;
            mismatch_q <= 1'b0;
            fail_q     <= 1'b0;
            mcnt_q     <= '0;
            ccnt_q     <= '0;
            fcyc_q     <= '0;
            fdiff_q    <= '0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
            mcnt_q     <= mcnt_d;
            ccnt_q     <= ccnt_d;
            fcyc_q     <= fcyc_d;
            fdiff_q    <= fdiff_d;
        end
    end

`ifdef EQUIV_ASSERT_EN
    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_compare) begin
            assert (diff == '0);
        end
    end
`endif

    assign mismatch     = mismatch_q;
    assign fail         = fail_q;
    assign state        = state_q;
    assign mismatch_cnt = mcnt_q;
    assign cycle_cnt    = ccnt_q;
    assign first_cycle  = fcyc_q;
    assign first_diff   = fdiff_q;

endmodule
